id_ex_mem_pipe: RTL and testbench

- Execute-side pipeline slice of the 5-stage MIPS core.
- Contains three parts:
  - combinational ALU-control decoder (decode stage);
  - ID/EX pipeline register plus the EX-stage RegDst and ALUSrc muxes;
  - EX/MEM pipeline register.
- The ALU itself is external. This block drives the ALU operands and opcode, and captures the ALU result and zero flag back.

---
 rtl/cpu_pkg.sv | 78 +++++++
 rtl/alu_ctrl_dec.sv | 50 +++++
 rtl/id_ex_mem_pipe.sv | 132 +++++++++++++
 tb/tb_id_ex_mem_pipe.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the execute-side pipeline: ALU operation classes,
// ALU control opcodes, R-type funct codes and pipeline field widths.
package cpu_pkg;

    localparam int DATA_W    = 32;
    localparam int REG_W     = 5;
    localparam int ALUOP_W   = 4;
    localparam int ALUCTRL_W = 5;
    localparam int FUNCT_W   = 6;

    // ALU operation class from the main control unit
    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 4'd0;
    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 4'd1;
    localparam logic [ALUOP_W-1:0] ALUOP_ADDU  = 4'd2;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 4'd3;
    localparam logic [ALUOP_W-1:0] ALUOP_AND   = 4'd4;
    localparam logic [ALUOP_W-1:0] ALUOP_OR    = 4'd5;
    localparam logic [ALUOP_W-1:0] ALUOP_XOR   = 4'd6;
    localparam logic [ALUOP_W-1:0] ALUOP_SLT   = 4'd7;
    localparam logic [ALUOP_W-1:0] ALUOP_SLTU  = 4'd8;
    localparam logic [ALUOP_W-1:0] ALUOP_LUI   = 4'd9;

    // Opcodes understood by the external ALU
    localparam logic [ALUCTRL_W-1:0] ALU_ADD  = 5'd0;
    localparam logic [ALUCTRL_W-1:0] ALU_ADDU = 5'd1;
    localparam logic [ALUCTRL_W-1:0] ALU_SUB  = 5'd2;
    localparam logic [ALUCTRL_W-1:0] ALU_SUBU = 5'd3;
    localparam logic [ALUCTRL_W-1:0] ALU_AND  = 5'd4;
    localparam logic [ALUCTRL_W-1:0] ALU_OR   = 5'd5;
    localparam logic [ALUCTRL_W-1:0] ALU_XOR  = 5'd6;
    localparam logic [ALUCTRL_W-1:0] ALU_NOR  = 5'd7;
    localparam logic [ALUCTRL_W-1:0] ALU_SLT  = 5'd8;
    localparam logic [ALUCTRL_W-1:0] ALU_SLTU = 5'd9;
    localparam logic [ALUCTRL_W-1:0] ALU_SLL  = 5'd10;
    localparam logic [ALUCTRL_W-1:0] ALU_SRL  = 5'd11;
    localparam logic [ALUCTRL_W-1:0] ALU_SRA  = 5'd12;
    localparam logic [ALUCTRL_W-1:0] ALU_SLLV = 5'd13;
    localparam logic [ALUCTRL_W-1:0] ALU_SRLV = 5'd14;
    localparam logic [ALUCTRL_W-1:0] ALU_SRAV = 5'd15;
    localparam logic [ALUCTRL_W-1:0] ALU_LUI  = 5'd16;

    // R-type funct field, instruction [5:0]
    localparam logic [FUNCT_W-1:0] FN_SLL  = 6'h00;
    localparam logic [FUNCT_W-1:0] FN_SRL  = 6'h02;
    localparam logic [FUNCT_W-1:0] FN_SRA  = 6'h03;
    localparam logic [FUNCT_W-1:0] FN_SLLV = 6'h04;
    localparam logic [FUNCT_W-1:0] FN_SRLV = 6'h06;
    localparam logic [FUNCT_W-1:0] FN_SRAV = 6'h07;
    localparam logic [FUNCT_W-1:0] FN_ADD  = 6'h20;
    localparam logic [FUNCT_W-1:0] FN_ADDU = 6'h21;
    localparam logic [FUNCT_W-1:0] FN_SUB  = 6'h22;
    localparam logic [FUNCT_W-1:0] FN_SUBU = 6'h23;
    localparam logic [FUNCT_W-1:0] FN_AND  = 6'h24;
    localparam logic [FUNCT_W-1:0] FN_OR   = 6'h25;
    localparam logic [FUNCT_W-1:0] FN_XOR  = 6'h26;
    localparam logic [FUNCT_W-1:0] FN_NOR  = 6'h27;
    localparam logic [FUNCT_W-1:0] FN_SLT  = 6'h2A;
    localparam logic [FUNCT_W-1:0] FN_SLTU = 6'h2B;

    // Control bits carried through ID/EX
    typedef struct packed {
        logic                 regWrite;
        logic                 memtoReg;
        logic                 memWrite;
        logic                 aluSrc;
        logic                 regDst;
        logic [ALUCTRL_W-1:0] aluControl;
    } idExCtrlT;

    // Control bits carried through EX/MEM
    typedef struct packed {
        logic regWrite;
        logic memtoReg;
        logic memWrite;
        logic zero;
    } exMemCtrlT;

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU control decoder: maps ALUOp class (and funct for R-type) to an ALU opcode.
// Purely combinational, no latency; no flow control.
module alu_ctrl_dec
    import cpu_pkg::*;
(
    input  logic [ALUOP_W-1:0]   aluOp,
    input  logic [FUNCT_W-1:0]   funct,
    output logic [ALUCTRL_W-1:0] aluControl
);

    always_comb begin
        aluControl = ALU_ADD;
        if (aluOp == ALUOP_RTYPE) begin
            // Unknown funct codes fall back to ADD
            case (funct)
                FN_ADD:  aluControl = ALU_ADD;
                FN_ADDU: aluControl = ALU_ADDU;
                FN_SUB:  aluControl = ALU_SUB;
                FN_SUBU: aluControl = ALU_SUBU;
                FN_AND:  aluControl = ALU_AND;
                FN_OR:   aluControl = ALU_OR;
                FN_XOR:  aluControl = ALU_XOR;
                FN_NOR:  aluControl = ALU_NOR;
                FN_SLT:  aluControl = ALU_SLT;
                FN_SLTU: aluControl = ALU_SLTU;
                FN_SLL:  aluControl = ALU_SLL;
                FN_SRL:  aluControl = ALU_SRL;
                FN_SRA:  aluControl = ALU_SRA;
                FN_SLLV: aluControl = ALU_SLLV;
                FN_SRLV: aluControl = ALU_SRLV;
                FN_SRAV: aluControl = ALU_SRAV;
                default: aluControl = ALU_ADD;
            endcase
        end else begin
            case (aluOp)
                ALUOP_ADD:  aluControl = ALU_ADD;
                ALUOP_ADDU: aluControl = ALU_ADDU;
                ALUOP_SUB:  aluControl = ALU_SUB;
                ALUOP_AND:  aluControl = ALU_AND;
                ALUOP_OR:   aluControl = ALU_OR;
                ALUOP_XOR:  aluControl = ALU_XOR;
                ALUOP_SLT:  aluControl = ALU_SLT;
                ALUOP_SLTU: aluControl = ALU_SLTU;
                ALUOP_LUI:  aluControl = ALU_LUI;
                default:    aluControl = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/id_ex_mem_pipe.sv
// Execute-side MIPS slice: ALU control decode, ID/EX register with RegDst/ALUSrc muxes, EX/MEM register.
// Latency two clocks decode to MEM; no stall, flushE only bubbles the ID/EX stage.
module id_ex_mem_pipe
    import cpu_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int RW = REG_W
) (
    input  logic          clock,
    input  logic          reset,

    input  logic [3:0]    ALUOp,
    input  logic [5:0]    funct,
    output logic [4:0]    ALUControlD,

    input  logic          RegWriteD,
    input  logic          MemtoRegD,
    input  logic          MemWriteD,
    input  logic          ALUSrcD,
    input  logic          RegDstD,
    input  logic [DW-1:0] Readdata1D,
    input  logic [DW-1:0] Readdata2D,
    input  logic [RW-1:0] RtD,
    input  logic [RW-1:0] RdD,
    input  logic [DW-1:0] ImmD,
    input  logic [DW-1:0] PCPlus4D,
    input  logic          flushE,

    output logic          RegWriteE,
    output logic          MemtoRegE,
    output logic          MemWriteE,
    output logic [4:0]    ALUControlE,
    output logic [DW-1:0] SrcAE,
    output logic [DW-1:0] SrcBE,
    output logic [DW-1:0] ImmE,
    output logic [DW-1:0] PCPlus4E,
    output logic [RW-1:0] WriteRegE,

    input  logic [DW-1:0] ALUOutE,
    input  logic          ZeroE,

    output logic          RegWriteM,
    output logic          MemtoRegM,
    output logic          MemWriteM,
    output logic          ZeroM,
    output logic [DW-1:0] ALUOutM,
    output logic [DW-1:0] WriteDataM,
    output logic [RW-1:0] WriteRegM
);

    idExCtrlT      ctrlD;
    idExCtrlT      ctrlE;
    exMemCtrlT     ctrlM;
    logic [DW-1:0] readData2E;
    logic [RW-1:0] rtE;
    logic [RW-1:0] rdE;

    alu_ctrl_dec uDec (
        .aluOp      (ALUOp),
        .funct      (funct),
        .aluControl (ALUControlD)
    );

    assign ctrlD = '{
        regWrite:   RegWriteD,
        memtoReg:   MemtoRegD,
        memWrite:   MemWriteD,
        aluSrc:     ALUSrcD,
        regDst:     RegDstD,
        aluControl: ALUControlD
    };

    // ID/EX: a flush kills only the side-effecting controls; datapath fields still load
    always_ff @(posedge clock) begin
        if (reset) begin
            ctrlE      <= '0;
            SrcAE      <= '0;
            readData2E <= '0;
            ImmE       <= '0;
            PCPlus4E   <= '0;
            rtE        <= '0;
            rdE        <= '0;
        end else begin
            ctrlE      <= ctrlD;
            SrcAE      <= Readdata1D;
            readData2E <= Readdata2D;
            ImmE       <= ImmD;
            PCPlus4E   <= PCPlus4D;
            rtE        <= RtD;
            rdE        <= RdD;
            if (flushE) begin
                ctrlE.regWrite   <= 1'b0;
                ctrlE.memtoReg   <= 1'b0;
                ctrlE.memWrite   <= 1'b0;
                ctrlE.aluControl <= ALU_ADD;
            end
        end
    end

    assign RegWriteE   = ctrlE.regWrite;
    assign MemtoRegE   = ctrlE.memtoReg;
    assign MemWriteE   = ctrlE.memWrite;
    assign ALUControlE = ctrlE.aluControl;
    assign SrcBE       = ctrlE.aluSrc ? ImmE : readData2E;
    assign WriteRegE   = ctrlE.regDst ? rdE : rtE;

    // Store data is always rt, independent of the ALUSrc operand choice
    always_ff @(posedge clock) begin
        if (reset) begin
            ctrlM      <= '0;
            ALUOutM    <= '0;
            WriteDataM <= '0;
            WriteRegM  <= '0;
        end else begin
            ctrlM      <= '{
                regWrite: ctrlE.regWrite,
                memtoReg: ctrlE.memtoReg,
                memWrite: ctrlE.memWrite,
                zero:     ZeroE
            };
            ALUOutM    <= ALUOutE;
            WriteDataM <= readData2E;
            WriteRegM  <= WriteRegE;
        end
    end

    assign RegWriteM = ctrlM.regWrite;
    assign MemtoRegM = ctrlM.memtoReg;
    assign MemWriteM = ctrlM.memWrite;
    assign ZeroM     = ctrlM.zero;

endmodule

// File: tb/tb_id_ex_mem_pipe.sv
// Self-checking bench for id_ex_mem_pipe: directed cases then random traffic
// compared against a transaction-level model of the two pipeline stages.
module tb_id_ex_mem_pipe;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  ALUOp;
    logic [5:0]  funct;
    logic [4:0]  ALUControlD;
    logic        RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD;
    logic [31:0] Readdata1D, Readdata2D, ImmD, PCPlus4D;
    logic [4:0]  RtD, RdD;
    logic        flushE;
    logic        RegWriteE, MemtoRegE, MemWriteE;
    logic [4:0]  ALUControlE;
    logic [31:0] SrcAE, SrcBE, ImmE, PCPlus4E;
    logic [4:0]  WriteRegE;
    logic [31:0] ALUOutE;
    logic        ZeroE;
    logic        RegWriteM, MemtoRegM, MemWriteM, ZeroM;
    logic [31:0] ALUOutM, WriteDataM;
    logic [4:0]  WriteRegM;

    int nCompared = 0;
    int nMismatched = 0;

    always #5 clock = ~clock;

    id_ex_mem_pipe #(.DW(32), .RW(5)) dut (
        .clock(clock), .reset(reset),
        .ALUOp(ALUOp), .funct(funct), .ALUControlD(ALUControlD),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
        .ALUSrcD(ALUSrcD), .RegDstD(RegDstD),
        .Readdata1D(Readdata1D), .Readdata2D(Readdata2D),
        .RtD(RtD), .RdD(RdD), .ImmD(ImmD), .PCPlus4D(PCPlus4D),
        .flushE(flushE),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .ALUControlE(ALUControlE), .SrcAE(SrcAE), .SrcBE(SrcBE),
        .ImmE(ImmE), .PCPlus4E(PCPlus4E), .WriteRegE(WriteRegE),
        .ALUOutE(ALUOutE), .ZeroE(ZeroE),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .ZeroM(ZeroM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
        .WriteRegM(WriteRegM)
    );

    // Instruction as seen in EX and in MEM
    typedef struct {
        logic        regWrite, memtoReg, memWrite, aluSrc, regDst;
        logic [4:0]  aluCtrl;
        logic [31:0] rd1, rd2, imm, pc4;
        logic [4:0]  rt, rd;
    } exInstT;

    typedef struct {
        logic        regWrite, memtoReg, memWrite, zero;
        logic [31:0] aluOut, writeData;
        logic [4:0]  writeReg;
    } memInstT;

    exInstT  exStage;
    memInstT memStage;

    int rtypeMap[64];
    int opMap[16] = '{0, 0, 1, 2, 4, 5, 6, 8, 9, 16, 0, 0, 0, 0, 0, 0};

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [4:0] refDecode(input logic [3:0] op, input logic [5:0] fn);
        if (op == 4'd0) return 5'(rtypeMap[fn]);
        return 5'(opMap[op]);
    endfunction

    task automatic clearD();
        ALUOp = 4'd0; funct = 6'h20;
        RegWriteD = 0; MemtoRegD = 0; MemWriteD = 0; ALUSrcD = 0; RegDstD = 0;
        Readdata1D = '0; Readdata2D = '0; ImmD = '0; PCPlus4D = '0;
        RtD = '0; RdD = '0; flushE = 0; ALUOutE = '0; ZeroE = 0;
    endtask

    // One clock: check decoder, advance the model on the edge, check both stages
    task automatic cycle();
        exInstT nextEx;
        #1;
        check("ALUControlD", 32'(ALUControlD), 32'(refDecode(ALUOp, funct)));
        @(posedge clock);
        if (reset) begin
            exStage  = '{default: '0};
            memStage = '{default: '0};
        end else begin
            memStage.regWrite  = exStage.regWrite;
            memStage.memtoReg  = exStage.memtoReg;
            memStage.memWrite  = exStage.memWrite;
            memStage.zero      = ZeroE;
            memStage.aluOut    = ALUOutE;
            memStage.writeData = exStage.rd2;
            memStage.writeReg  = exStage.regDst ? exStage.rd : exStage.rt;
            nextEx = '{regWrite: RegWriteD && !flushE, memtoReg: MemtoRegD && !flushE,
                       memWrite: MemWriteD && !flushE, aluSrc: ALUSrcD, regDst: RegDstD,
                       aluCtrl: flushE ? 5'd0 : refDecode(ALUOp, funct),
                       rd1: Readdata1D, rd2: Readdata2D, imm: ImmD, pc4: PCPlus4D,
                       rt: RtD, rd: RdD};
            exStage = nextEx;
        end
        @(negedge clock);
        check("RegWriteE", 32'(RegWriteE), 32'(exStage.regWrite));
        check("MemtoRegE", 32'(MemtoRegE), 32'(exStage.memtoReg));
        check("MemWriteE", 32'(MemWriteE), 32'(exStage.memWrite));
        check("ALUControlE", 32'(ALUControlE), 32'(exStage.aluCtrl));
        check("SrcAE", SrcAE, exStage.rd1);
        check("SrcBE", SrcBE, exStage.aluSrc ? exStage.imm : exStage.rd2);
        check("ImmE", ImmE, exStage.imm);
        check("PCPlus4E", PCPlus4E, exStage.pc4);
        check("WriteRegE", 32'(WriteRegE), 32'(exStage.regDst ? exStage.rd : exStage.rt));
        check("RegWriteM", 32'(RegWriteM), 32'(memStage.regWrite));
        check("MemtoRegM", 32'(MemtoRegM), 32'(memStage.memtoReg));
        check("MemWriteM", 32'(MemWriteM), 32'(memStage.memWrite));
        check("ZeroM", 32'(ZeroM), 32'(memStage.zero));
        check("ALUOutM", ALUOutM, memStage.aluOut);
        check("WriteDataM", WriteDataM, memStage.writeData);
        check("WriteRegM", 32'(WriteRegM), 32'(memStage.writeReg));
    endtask

    initial begin
        logic [5:0] sweepFn[17];
        int         sweepExp[17];
        logic [5:0] knownFn[16];

        for (int i = 0; i < 64; i++) rtypeMap[i] = 0;
        rtypeMap[6'h20] = 0;  rtypeMap[6'h21] = 1;  rtypeMap[6'h22] = 2;  rtypeMap[6'h23] = 3;
        rtypeMap[6'h24] = 4;  rtypeMap[6'h25] = 5;  rtypeMap[6'h26] = 6;  rtypeMap[6'h27] = 7;
        rtypeMap[6'h2A] = 8;  rtypeMap[6'h2B] = 9;
        rtypeMap[6'h00] = 10; rtypeMap[6'h02] = 11; rtypeMap[6'h03] = 12;
        rtypeMap[6'h04] = 13; rtypeMap[6'h06] = 14; rtypeMap[6'h07] = 15;

        sweepFn  = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                     6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h3F};
        sweepExp = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 0};
        for (int i = 0; i < 16; i++) knownFn[i] = sweepFn[i];

        exStage  = '{default: '0};
        memStage = '{default: '0};
        clearD();
        reset = 1'b1;

        // Combinational R-type funct sweep
        for (int i = 0; i < 17; i++) begin
            funct = sweepFn[i];
            #1;
            check($sformatf("funct_%0h", sweepFn[i]), 32'(ALUControlD), 32'(sweepExp[i]));
        end
        ALUOp = 4'd9; #1; check("aluop_lui", 32'(ALUControlD), 32'd16);
        ALUOp = 4'd12; #1; check("aluop_12", 32'(ALUControlD), 32'd0);
        clearD();

        // Reset for one cycle
        cycle();
        check("rst_ALUControlE", 32'(ALUControlE), 32'd0);
        check("rst_RegWriteM", 32'(RegWriteM), 32'd0);
        reset = 1'b0;

        // R-type add
        Readdata1D = 32'd5; Readdata2D = 32'd7; RdD = 5'd3; RtD = 5'd2;
        RegDstD = 1; ALUSrcD = 0; RegWriteD = 1;
        cycle();
        check("add_SrcAE", SrcAE, 32'd5);
        check("add_SrcBE", SrcBE, 32'd7);
        check("add_WriteRegE", 32'(WriteRegE), 32'd3);
        check("add_ALUControlE", 32'(ALUControlE), 32'd0);
        clearD();
        ALUOutE = 32'd12;
        cycle();
        check("add_ALUOutM", ALUOutM, 32'd12);
        check("add_WriteRegM", 32'(WriteRegM), 32'd3);
        check("add_RegWriteM", 32'(RegWriteM), 32'd1);

        // Store word: SrcB is the immediate, store data is rt
        clearD();
        ALUOp = 4'd1; ALUSrcD = 1; ImmD = 32'h10; Readdata2D = 32'hDEADBEEF; MemWriteD = 1;
        cycle();
        check("sw_SrcBE", SrcBE, 32'h10);
        clearD();
        cycle();
        check("sw_WriteDataM", WriteDataM, 32'hDEADBEEF);
        check("sw_MemWriteM", 32'(MemWriteM), 32'd1);

        // Flush inserts a bubble
        clearD();
        ALUOp = 4'd5; RegWriteD = 1; MemWriteD = 1; flushE = 1;
        cycle();
        check("flush_RegWriteE", 32'(RegWriteE), 32'd0);
        check("flush_MemWriteE", 32'(MemWriteE), 32'd0);
        check("flush_ALUControlE", 32'(ALUControlE), 32'd0);
        clearD();
        cycle();
        check("flush_RegWriteM", 32'(RegWriteM), 32'd0);

        // Reset mid-stream wins over flush and new data
        clearD();
        RegWriteD = 1; MemWriteD = 1; ALUOp = 4'd4; Readdata1D = 32'hA5A5; ImmD = 32'h77;
        cycle();
        ALUOutE = 32'h1234; ZeroE = 1;
        cycle();
        reset = 1; flushE = 1; RegWriteD = 1;
        cycle();
        check("midrst_RegWriteE", 32'(RegWriteE), 32'd0);
        check("midrst_SrcAE", SrcAE, 32'd0);
        check("midrst_RegWriteM", 32'(RegWriteM), 32'd0);
        check("midrst_ALUOutM", ALUOutM, 32'd0);
        reset = 0;
        clearD();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            reset      = ($urandom_range(0, 39) == 0);
            flushE     = ($urandom_range(0, 4) == 0);
            ALUOp      = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            funct      = ($urandom_range(0, 3) == 0) ? 6'($urandom) : knownFn[$urandom_range(0, 15)];
            RegWriteD  = 1'($urandom);
            MemtoRegD  = 1'($urandom);
            MemWriteD  = 1'($urandom);
            ALUSrcD    = 1'($urandom);
            RegDstD    = 1'($urandom);
            Readdata1D = $urandom;
            Readdata2D = $urandom;
            ImmD       = $urandom;
            PCPlus4D   = $urandom;
            RtD        = 5'($urandom);
            RdD        = 5'($urandom);
            ALUOutE    = $urandom;
            ZeroE      = 1'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
